// File: rtl/img_ctrl_pkg.sv
// Shared types for the image window controller: command codes, FSM states
// and the raster index helper used to locate the 2x2 window in the buffer.
package img_ctrl_pkg;

   typedef enum logic [3:0] {
      CMD_WRITE  = 4'd0,
      CMD_UP     = 4'd1,
      CMD_DOWN   = 4'd2,
      CMD_LEFT   = 4'd3,
      CMD_RIGHT  = 4'd4,
      CMD_MAX    = 4'd5,
      CMD_MIN    = 4'd6,
      CMD_AVG    = 4'd7,
      CMD_CCW    = 4'd8,
      CMD_CW     = 4'd9,
      CMD_MIRX   = 4'd10,
      CMD_MIRY   = 4'd11,
      CMD_RELOAD = 4'd12,
      CMD_NOP0   = 4'd13,
      CMD_NOP1   = 4'd14,
      CMD_NOP2   = 4'd15
   } cmd_e;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_IDLE,
      ST_EXEC,
      ST_WRITE
   } state_e;

   function automatic int unsigned win_idx(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned width);
      return row * width + col;
   endfunction

endpackage

// File: rtl/img_window_alu.sv
// Combinational 2x2 window processor: extremes, average, rotations, mirrors.
// Commands it does not handle pass the four pixels through unchanged.
module img_window_alu
   import img_ctrl_pkg::*;
#(
   parameter int DW = 8
) (
   input  cmd_e          cmd_i,
   input  logic [DW-1:0] tl_i,
   input  logic [DW-1:0] tr_i,
   input  logic [DW-1:0] bl_i,
   input  logic [DW-1:0] br_i,
   output logic [DW-1:0] tl_o,
   output logic [DW-1:0] tr_o,
   output logic [DW-1:0] bl_o,
   output logic [DW-1:0] br_o
);

   logic [DW-1:0] max_top, max_bot, max_all;
   logic [DW-1:0] min_top, min_bot, min_all;
   logic [DW+1:0] sum;
   logic [DW-1:0] avg;

   always_comb begin
      max_top = (tl_i > tr_i) ? tl_i : tr_i;
      max_bot = (bl_i > br_i) ? bl_i : br_i;
      max_all = (max_top > max_bot) ? max_top : max_bot;
      min_top = (tl_i < tr_i) ? tl_i : tr_i;
      min_bot = (bl_i < br_i) ? bl_i : br_i;
      min_all = (min_top < min_bot) ? min_top : min_bot;
      // Two guard bits hold the four-pixel sum without overflow.
      sum = {2'b00, tl_i} + {2'b00, tr_i} + {2'b00, bl_i} + {2'b00, br_i};
      avg = DW'(sum >> 2);

      tl_o = tl_i;
      tr_o = tr_i;
      bl_o = bl_i;
      br_o = br_i;
      case (cmd_i)
         CMD_MAX: begin
            tl_o = max_all; tr_o = max_all; bl_o = max_all; br_o = max_all;
         end
         CMD_MIN: begin
            tl_o = min_all; tr_o = min_all; bl_o = min_all; br_o = min_all;
         end
         CMD_AVG: begin
            tl_o = avg; tr_o = avg; bl_o = avg; br_o = avg;
         end
         CMD_CW: begin
            tl_o = bl_i; bl_o = br_i; br_o = tr_i; tr_o = tl_i;
         end
         CMD_CCW: begin
            tl_o = tr_i; tr_o = br_i; br_o = bl_i; bl_o = tl_i;
         end
         CMD_MIRX: begin
            tl_o = bl_i; bl_o = tl_i; tr_o = br_i; br_o = tr_i;
         end
         CMD_MIRY: begin
            tl_o = tr_i; tr_o = tl_i; bl_o = br_i; br_o = bl_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/img_window_ctrl.sv
// Image window controller: loads an image from ROM, applies window commands
// to an internal buffer and streams the buffer out to RAM on WRITE.
module img_window_ctrl
   import img_ctrl_pkg::*;
#(
   parameter int DW    = 8,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [3:0]                            cmd,
   input  logic                                  cmd_valid,
   output logic                                  busy,
   output logic                                  rom_rd,
   output logic [$clog2(IMG_W*IMG_H)-1:0]        rom_a,
   input  logic [DW-1:0]                         rom_q,
   output logic                                  ram_valid,
   output logic [$clog2(IMG_W*IMG_H)-1:0]        ram_a,
   output logic [DW-1:0]                         ram_d,
   output logic                                  done
);

   localparam int N  = IMG_W * IMG_H;
   localparam int AW = $clog2(N);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   state_e        state_q, state_d;
   cmd_e          cmd_q;
   logic [XW-1:0] ox_q;
   logic [YW-1:0] oy_q;
   logic [AW:0]   iss_q;
   logic          rom_rd_q, cap_vld_q;
   logic [AW-1:0] rom_a_q, cap_a_q;
   logic          ram_valid_q, done_q;
   logic [AW-1:0] ram_a_q, ram_a_nx;
   logic [DW-1:0] ram_d_q;
   logic [DW-1:0] buf_q [N];

   logic          accept;
   logic [AW-1:0] idx_tl, idx_tr, idx_bl, idx_br;
   logic [DW-1:0] alu_tl, alu_tr, alu_bl, alu_br;

   assign accept   = cmd_valid && (state_q == ST_IDLE);
   assign ram_a_nx = ram_a_q + AW'(1);

   assign idx_tl = AW'(win_idx(32'(oy_q) - 1, 32'(ox_q) - 1, IMG_W));
   assign idx_tr = AW'(win_idx(32'(oy_q) - 1, 32'(ox_q),     IMG_W));
   assign idx_bl = AW'(win_idx(32'(oy_q),     32'(ox_q) - 1, IMG_W));
   assign idx_br = AW'(win_idx(32'(oy_q),     32'(ox_q),     IMG_W));

   img_window_alu #(.DW(DW)) u_alu (
      .cmd_i (cmd_q),
      .tl_i  (buf_q[idx_tl]),
      .tr_i  (buf_q[idx_tr]),
      .bl_i  (buf_q[idx_bl]),
      .br_i  (buf_q[idx_br]),
      .tl_o  (alu_tl),
      .tr_o  (alu_tr),
      .bl_o  (alu_bl),
      .br_o  (alu_br)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD:  if (cap_vld_q && (cap_a_q == AW'(N - 1))) state_d = ST_IDLE;
         ST_IDLE: begin
            if (accept) begin
               case (cmd_e'(cmd))
                  CMD_WRITE:  state_d = ST_WRITE;
                  CMD_RELOAD: state_d = ST_LOAD;
                  default:    state_d = ST_EXEC;
               endcase
            end
         end
         ST_EXEC:  state_d = ST_IDLE;
         ST_WRITE: if (ram_a_q == AW'(N - 1)) state_d = ST_IDLE;
         default:  state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_LOAD;
         cmd_q       <= CMD_NOP0;
         ox_q        <= XW'(IMG_W / 2);
         oy_q        <= YW'(IMG_H / 2);
         iss_q       <= '0;
         rom_rd_q    <= 1'b0;
         rom_a_q     <= '0;
         cap_vld_q   <= 1'b0;
         cap_a_q     <= '0;
         ram_valid_q <= 1'b0;
         ram_a_q     <= '0;
         ram_d_q     <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         // ROM data lags the address by one cycle, so the capture slot follows the read.
         cap_vld_q <= rom_rd_q;
         cap_a_q   <= rom_a_q;
         case (state_q)
            ST_LOAD: begin
               if (iss_q < (AW+1)'(N)) begin
                  rom_rd_q <= 1'b1;
                  rom_a_q  <= iss_q[AW-1:0];
                  iss_q    <= iss_q + (AW+1)'(1);
               end else begin
                  rom_rd_q <= 1'b0;
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  cmd_q  <= cmd_e'(cmd);
                  done_q <= 1'b0;
                  if (cmd_e'(cmd) == CMD_WRITE) begin
                     ram_valid_q <= 1'b1;
                     ram_a_q     <= '0;
                     ram_d_q     <= buf_q[0];
                  end else if (cmd_e'(cmd) == CMD_RELOAD) begin
                     iss_q <= '0;
                     ox_q  <= XW'(IMG_W / 2);
                     oy_q  <= YW'(IMG_H / 2);
                  end
               end
            end
            ST_EXEC: begin
               case (cmd_q)
                  CMD_UP:    if (oy_q > YW'(1))         oy_q <= oy_q - YW'(1);
                  CMD_DOWN:  if (oy_q < YW'(IMG_H - 1)) oy_q <= oy_q + YW'(1);
                  CMD_LEFT:  if (ox_q > XW'(1))         ox_q <= ox_q - XW'(1);
                  CMD_RIGHT: if (ox_q < XW'(IMG_W - 1)) ox_q <= ox_q + XW'(1);
                  default: ;
               endcase
            end
            ST_WRITE: begin
               if (ram_a_q == AW'(N - 1)) begin
                  ram_valid_q <= 1'b0;
                  done_q      <= 1'b1;
               end else begin
                  ram_a_q <= ram_a_nx;
                  ram_d_q <= buf_q[ram_a_nx];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if ((state_q == ST_LOAD) && cap_vld_q) buf_q[cap_a_q] <= rom_q;
      if (state_q == ST_EXEC) begin
         buf_q[idx_tl] <= alu_tl;
         buf_q[idx_tr] <= alu_tr;
         buf_q[idx_bl] <= alu_bl;
         buf_q[idx_br] <= alu_br;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign rom_rd    = rom_rd_q;
   assign rom_a     = rom_a_q;
   assign ram_valid = ram_valid_q;
   assign ram_a     = ram_a_q;
   assign ram_d     = ram_d_q;
   assign done      = done_q;

endmodule

// File: tb/tb_img_window_ctrl.sv
// Bench for img_window_ctrl: 8x8 instance driven by a command table and
// hand sequences, plus a 16x4 instance for the parameterised load/origin.
module tb_img_window_ctrl;

   localparam int N = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst1, cv1, busy1, rom_rd1, ramv1, done1;
   logic [3:0] cmd1;
   logic [5:0] rom_a1, ram_a1;
   logic [7:0] rom_q1, ram_d1;

   logic       rst2, cv2, busy2, rom_rd2, ramv2, done2;
   logic [3:0] cmd2;
   logic [5:0] rom_a2, ram_a2;
   logic [7:0] rom_q2, ram_d2;

   logic [7:0] rom1 [N];
   logic [7:0] rom2 [N];

   always @(posedge clk) if (rom_rd1) rom_q1 <= rom1[rom_a1];
   always @(posedge clk) if (rom_rd2) rom_q2 <= rom2[rom_a2];

   img_window_ctrl #(.DW(8), .IMG_W(8), .IMG_H(8)) dut1 (
      .clk(clk), .reset(rst1), .cmd(cmd1), .cmd_valid(cv1), .busy(busy1),
      .rom_rd(rom_rd1), .rom_a(rom_a1), .rom_q(rom_q1),
      .ram_valid(ramv1), .ram_a(ram_a1), .ram_d(ram_d1), .done(done1)
   );

   img_window_ctrl #(.DW(8), .IMG_W(16), .IMG_H(4)) dut2 (
      .clk(clk), .reset(rst2), .cmd(cmd2), .cmd_valid(cv2), .busy(busy2),
      .rom_rd(rom_rd2), .rom_a(rom_a2), .rom_q(rom_q2),
      .ram_valid(ramv2), .ram_a(ram_a2), .ram_d(ram_d2), .done(done2)
   );

   typedef struct { int a; int d; } sb_t;
   typedef struct { logic [3:0] c; int ox; int oy; int tl; int tr; int bl; int br; } vec_t;

   sb_t  exp_q [$];
   int   mimg  [N];
   vec_t tbl   [13];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_reset1();
      chk("rst_busy", busy1, 1);
      chk("rst_rom_rd", rom_rd1, 0);
      chk("rst_rom_a", rom_a1, 0);
      chk("rst_ram_valid", ramv1, 0);
      chk("rst_ram_a", ram_a1, 0);
      chk("rst_ram_d", ram_d1, 0);
      chk("rst_done", done1, 0);
   endtask

   task automatic model_identity();
      for (int i = 0; i < N; i++) mimg[i] = i;
   endtask

   task automatic wait_idle1();
      int n;
      n = 0;
      while (busy1 !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", busy1, 0);
   endtask

   task automatic do_cmd1(input logic [3:0] c);
      wait_idle1();
      cmd1 = c;
      cv1  = 1'b1;
      @(posedge clk); #1;
      cv1 = 1'b0;
      chk("busy_after_accept", busy1, 1);
      if (c != 4'd0 && c != 4'd12) begin
         @(posedge clk); #1;
         chk("busy_one_cycle", busy1, 0);
      end
   endtask

   task automatic do_write1();
      sb_t e;
      bit  fin;
      fin = 1'b0;
      for (int i = 0; i < N; i++) exp_q.push_back('{i, mimg[i]});
      do_cmd1(4'd0);
      chk("done_cleared", done1, 0);
      for (int cyc = 0; cyc < N + 4 && !fin; cyc++) begin
         if (ramv1) begin
            if (exp_q.size() == 0) begin
               chk("extra_word", ramv1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("ram_a", ram_a1, e.a);
               chk("ram_d", ram_d1, e.d);
            end
         end else begin
            chk("words_pending", exp_q.size(), 0);
            chk("done_at_end", done1, 1);
            chk("busy_at_end", busy1, 0);
            fin = 1'b1;
         end
         if (!fin) begin
            @(posedge clk); #1;
         end
      end
      chk("write_finished", fin, 1);
      exp_q.delete();
   endtask

   task automatic set_win(input int ox, input int oy, input int tl, input int tr,
                          input int bl, input int br);
      mimg[(oy - 1) * 8 + ox - 1] = tl;
      mimg[(oy - 1) * 8 + ox]     = tr;
      mimg[oy * 8 + ox - 1]       = bl;
      mimg[oy * 8 + ox]           = br;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int got2 [N];
      int exp2 [N];
      int cnt2;

      for (int i = 0; i < N; i++) begin
         rom1[i] = 8'(i);
         rom2[i] = 8'(i * 3);
      end
      tbl[0]  = '{4'd9,  4, 4, 35, 27, 36, 28};
      tbl[1]  = '{4'd8,  4, 4, 27, 28, 35, 36};
      tbl[2]  = '{4'd10, 4, 4, 35, 36, 27, 28};
      tbl[3]  = '{4'd10, 4, 4, 27, 28, 35, 36};
      tbl[4]  = '{4'd11, 4, 4, 28, 27, 36, 35};
      tbl[5]  = '{4'd11, 4, 4, 27, 28, 35, 36};
      tbl[6]  = '{4'd4,  5, 4, 28, 29, 36, 37};
      tbl[7]  = '{4'd5,  5, 4, 37, 37, 37, 37};
      tbl[8]  = '{4'd3,  4, 4, 27, 37, 35, 37};
      tbl[9]  = '{4'd6,  4, 4, 27, 27, 27, 27};
      tbl[10] = '{4'd2,  4, 5, 27, 27, 43, 44};
      tbl[11] = '{4'd7,  4, 5, 35, 35, 35, 35};
      tbl[12] = '{4'd14, 4, 5, 35, 35, 35, 35};

      rst1 = 1'b1; rst2 = 1'b1;
      cmd1 = 4'd0; cv1 = 1'b0; cmd2 = 4'd0; cv2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset1();

      // LOAD with a MAX command held on cmd_valid the whole time
      cmd1 = 4'd5; cv1 = 1'b1;
      @(negedge clk); rst1 = 1'b0;
      for (int k = 0; k < N; k++) begin
         @(posedge clk); #1;
         chk("load_rom_rd", rom_rd1, 1);
         chk("load_rom_a", rom_a1, k);
      end
      cv1 = 1'b0;
      @(posedge clk); #1;
      chk("load_rd_drop", rom_rd1, 0);
      chk("load_busy_last", busy1, 1);
      @(posedge clk); #1;
      chk("load_busy_end", busy1, 0);

      model_identity();
      do_write1();

      for (int t = 0; t < 13; t++) begin
         do_cmd1(tbl[t].c);
         set_win(tbl[t].ox, tbl[t].oy, tbl[t].tl, tbl[t].tr, tbl[t].bl, tbl[t].br);
         do_write1();
      end

      do_cmd1(4'd12);
      model_identity();
      repeat (4) do_cmd1(4'd9);
      do_write1();
      repeat (5) do_cmd1(4'd1);
      do_cmd1(4'd10);
      mimg[3] = 11; mimg[4] = 12; mimg[11] = 3; mimg[12] = 4;
      do_write1();

      do_cmd1(4'd12);
      model_identity();
      do_cmd1(4'd5);
      set_win(4, 4, 36, 36, 36, 36);
      do_write1();

      do_cmd1(4'd12);
      model_identity();
      do_cmd1(4'd7);
      set_win(4, 4, 31, 31, 31, 31);
      do_write1();

      // reset in the middle of a write-out
      wait_idle1();
      cmd1 = 4'd0; cv1 = 1'b1;
      @(posedge clk); #1;
      cv1 = 1'b0;
      n = 0;
      while (!(ramv1 && ram_a1 == 6'd20) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reached_word20", ram_a1, 20);
      #2 rst1 = 1'b1;
      #1;
      chk_reset1();
      @(negedge clk); rst1 = 1'b0;
      @(posedge clk); #1;
      chk("reload_rom_rd", rom_rd1, 1);
      chk("reload_rom_a", rom_a1, 0);
      chk("reload_done", done1, 0);
      chk("reload_busy", busy1, 1);
      wait_idle1();
      chk("done_after_abort", done1, 0);
      model_identity();
      do_write1();

      // 16x4 instance: load length and centre origin
      @(negedge clk); rst2 = 1'b0;
      n = 0;
      @(posedge clk); #1;
      while (busy2 && n < 200) begin
         n++;
         @(posedge clk); #1;
      end
      chk("load2_busy_cycles", n, 65);
      cmd2 = 4'd5; cv2 = 1'b1;
      @(posedge clk); #1;
      cv2 = 1'b0;
      @(posedge clk); #1;
      chk("max2_one_cycle", busy2, 0);
      cmd2 = 4'd0; cv2 = 1'b1;
      @(posedge clk); #1;
      cv2 = 1'b0;
      for (int i = 0; i < N; i++) begin
         got2[i] = -1;
         exp2[i] = (i * 3) % 256;
      end
      exp2[23] = 120; exp2[24] = 120; exp2[39] = 120; exp2[40] = 120;
      cnt2 = 0;
      for (int cyc = 0; cyc < N + 4; cyc++) begin
         if (ramv2) begin
            got2[ram_a2] = ram_d2;
            cnt2++;
         end
         @(posedge clk); #1;
      end
      chk("write2_words", cnt2, N);
      chk("write2_done", done2, 1);
      for (int i = 0; i < N; i++) chk("write2_pixel", got2[i], exp2[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/img_window_ctrl.md
# img_window_ctrl

Parametrised image display controller and successor to the fixed 8x8 LCD controller. It loads a IMG_W x IMG_H pixel image from a synchronous ROM into an internal buffer and applies host commands to a movable 2x2 window. These commands are shift, max/min/average, rotate, mirror and reload. A write command streams the processed image to an external RAM. The block sits between the command-issuing testbench/host and the image ROM/RAM pair.

## Interface
- DW, 8, pixel width in bits
- IMG_W, 8, image width in pixels; power of 2, 4..64
- IMG_H, 8, image height in pixels; power of 2, 4..64
- N (local), IMG_W*IMG_H, pixel count; AW (local), $clog2(N), address width
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- cmd  in  4  command code
- cmd_valid  in  1  command strobe
- busy  out  1  high while a load, command or write is in progress
- rom_rd  out  1  ROM read enable
- rom_a  out  AW  ROM address, raster order (row*IMG_W+col)
- rom_q  in  DW  ROM data; valid the cycle after rom_a/rom_rd
- ram_valid  out  1  RAM write strobe
- ram_a  out  AW  RAM address
- ram_d  out  DW  RAM data
- done  out  1  image write-out complete

## Operation
- **Command codes:**
  - 0 WRITE; 1 UP; 2 DOWN; 3 LEFT; 4 RIGHT
  - 5 MAX; 6 MIN; 7 AVG
  - 8 CCW; 9 CW; 10 MIRX; 11 MIRY
  - 12 RELOAD; 13–15 NOP
- **Window origin:**
  - Origin (ox, oy) is the lower-right window pixel, with ox in 1..IMG_W-1 and oy in 1..IMG_H-1.
  - Reset/reload value is (IMG_W/2, IMG_H/2).
  - Window pixels: TL=(oy-1,ox-1), TR=(oy-1,ox), BL=(oy,ox-1), BR=(oy,ox).
- **Shifts:** UP/DOWN change oy by -1/+1 and LEFT/RIGHT change ox by -1/+1. A shift that would leave the range is a no-op, but the command is still accepted and takes its cycle.
- **Arithmetic:**
  - MAX and MIN write the unsigned extreme of the four pixels to all four pixels.
  - AVG writes floor((TL+TR+BL+BR)/4) to all four pixels. The sum is held in DW+2 bits, so there is no overflow.
- **Rotate and mirror:**
  - CW: TL←BL, BL←BR, BR←TR, TR←TL.
  - CCW: TL←TR, TR←BR, BR←BL, BL←TL.
  - MIRX swaps the rows (TL↔BL, TR↔BR); MIRY swaps the columns (TL↔TR, BL↔BR).
  - All four updates are simultaneous, with no read-after-write within the command.
- **RELOAD:** re-runs LOAD over the whole buffer and resets the origin to the centre.
- **NOP:** codes 13–15 cost one EXEC cycle and change nothing.
- **State machine:** LOAD, IDLE, EXEC, WRITE.
  - Reset goes to LOAD.
  - LOAD goes to IDLE after N captures.
  - IDLE goes to EXEC on an accepted non-WRITE/non-RELOAD command.
  - IDLE goes to WRITE on accepted WRITE, and to LOAD on accepted RELOAD.
  - EXEC goes to IDLE. WRITE goes to IDLE after N words.
- **Handshake:**
  - A command is accepted at a rising edge only when cmd_valid=1 and busy=0.
  - cmd_valid while busy=1 is ignored, never queued.
- **done:**
  - Rises together with busy falling at the end of WRITE.
  - Cleared on the next accepted command or on reset.
- **Reset mid-operation:** any in-flight load, EXEC or WRITE is abandoned. All outputs return to reset values, and LOAD restarts from address 0 on the first edge after release.

## Timing
- **Reset values:** busy=1, rom_rd=0, rom_a=0, ram_valid=0, ram_a=0, ram_d=0, done=0. Buffer contents are don't-care until loaded.
- **LOAD:**
  - In cycles 0..N-1, rom_rd=1 and rom_a=k.
  - Pixel k is captured at the end of cycle k+1 from rom_q.
  - rom_rd drops after cycle N-1.
  - busy drops in cycle N+1, so the total is N+1 busy cycles after the first LOAD cycle.
- **Non-write commands:** accept at edge t. busy=1 in cycle t..t+1 (one EXEC cycle). The buffer/origin update is visible, and busy=0, from edge t+1.
- **WRITE:**
  - Accept at edge t.
  - For k=0..N-1, ram_valid=1, ram_a=k and ram_d=buffer[k] are registered together in cycle t+1+k.
  - In cycle t+1+N: ram_valid=0, busy=0, done=1.
- **Back-to-back commands:** a new command may be accepted at the first edge where busy=0 is sampled.

## Structure
- **Shared package img_ctrl_pkg:**
  - cmd_e enum (codes above).
  - state_e enum (LOAD, IDLE, EXEC, WRITE).
  - Helper function for window index computation.
- **Sub-module img_window_alu:**
  - Combinational.
  - Inputs: cmd and the four DW-bit pixels.
  - Outputs: four DW-bit results. Covers MAX/MIN/AVG/CW/CCW/MIRX/MIRY.
- **Top level:** holds the FSM, counters, origin registers and the N x DW buffer.

## Test plan
- **Default load + write:** 8x8, ROM[i]=i, reset then WRITE → 64 ram_valid cycles with ram_a=ram_d=0..63, then done=1 and busy=0 in the same cycle.
- **Max/Avg:** origin (4,4), pixels 27/28/35/36. MAX then WRITE → addresses 27, 28, 35 and 36 each hold 36. Separate run, AVG → 31 (126>>2).
- **Clockwise:** CW at (4,4) → TL=35, TR=27, BL=36, BR=28. CW applied 4 times → original image.
- **Saturation:** UP x5 from oy=4 → oy=3, 2, 1, 1, 1. Then MIRX → swaps rows 0 and 1 at columns 3 and 4; each command busy for exactly one cycle.
- **Busy gating:** cmd_valid=1 held with MAX during LOAD → ignored, image unchanged after WRITE. Also 16x4 parameterisation: load 65 busy cycles, origin (8,2).
- **Reset mid-WRITE:** assert reset at word 20 → outputs at reset values immediately; LOAD restarts at rom_a=0; done stays 0.
